// File: rtl/game_tick_scheduler_pkg.sv
// Shared defaults for the tick scheduler: channel count, divisor width, reset divisor.
package game_tick_scheduler_pkg;
  localparam int N_CH_DEF        = 4;
  localparam int DIV_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 15;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/game_tick_scheduler_tick_channel.sv
// One tick channel: down-counter with reload, registered one-cycle strobe at zero.
module game_tick_scheduler_tick_channel
  import game_tick_scheduler_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             reload,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             load_en,
  output logic             tick,
  output logic             en
);
  logic [DIV_W-1:0] cnt, div;

  // Priority: config apply > sync reload > normal counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= DIV_W'(DEFAULT_DIV);
      div  <= DIV_W'(DEFAULT_DIV);
      en   <= 1'b0;
      tick <= 1'b0;
    end else if (load) begin
      div  <= load_div;
      en   <= load_en;
      cnt  <= load_div;
      tick <= 1'b0;
    end else if (reload) begin
      cnt  <= div;
      tick <= 1'b0;
    end else if (en && adv) begin
      if (cnt == '0) begin
        tick <= 1'b1;
        cnt  <= div;
      end else begin
        tick <= 1'b0;
        cnt  <= cnt - 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/game_tick_scheduler.sv
// Programmable tick scheduler: per-channel enable strobes, two-phase config write,
// global pause/step/sync.
module game_tick_scheduler
  import game_tick_scheduler_pkg::*;
#(
  parameter  int N_CH        = N_CH_DEF,
  parameter  int DIV_W       = DIV_W_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             pause,
  input  logic             step,
  input  logic             sync,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  ch_en
);
  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
    logic             en;
  } cfg_req_t;

  cfg_req_t        hold;
  logic            apply, adv;
  logic [N_CH-1:0] load;

  // cfg_ready low marks the apply cycle of the held write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_ready <= 1'b1;
      hold      <= '0;
    end else if (cfg_ready) begin
      if (cfg_valid) begin
        hold      <= '{ch: cfg_ch, div: cfg_div, en: cfg_en};
        cfg_ready <= 1'b0;
      end
    end else begin
      cfg_ready <= 1'b1;
    end
  end

  assign apply = !cfg_ready;
  assign adv   = !pause || step;

  always_comb begin
    load = '0;
    if (apply) load[hold.ch] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    game_tick_scheduler_tick_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .adv     (adv),
      .reload  (sync),
      .load    (load[i]),
      .load_div(hold.div),
      .load_en (hold.en),
      .tick    (tick[i]),
      .en      (ch_en[i])
    );
  end
endmodule
